// File: rtl/spi_master_gen_if.sv
// Command and serial-bus signal bundle for spi_master_gen.
// The master modport is the SPI engine's view; slave is the controller/bench view.
interface spi_master_gen_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    logic              start;
    logic              rd_wr;
    logic [CSW-1:0]    cs_sel;
    logic              cpol;
    logic              cpha;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              miso;
    logic              mosi;
    logic              sclk;
    logic [NUM_CS-1:0] cs_n;

    modport master (
        input  start, rd_wr, cs_sel, cpol, cpha, address, wr_data, miso,
        output rd_data, busy, done, err, mosi, sclk, cs_n
    );

    modport slave (
        output start, rd_wr, cs_sel, cpol, cpha, address, wr_data, miso,
        input  rd_data, busy, done, err, mosi, sclk, cs_n
    );
endinterface

// File: rtl/spi_master_gen.sv
// SPI master: {rd_wr, address} header then a data word, MSB first, all CPOL/CPHA modes.
// Every output is registered so sclk, mosi and cs_n change only on half-period boundaries.
module spi_master_gen #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 2,
    parameter int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input logic              mclk,
    input logic              reset,
    spi_master_gen_if.master bus
);
    localparam int N      = ADDR_W + 1 + DATA_W;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * N + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * N);
    localparam logic [HALF_W-1:0] HALF_PEN  = HALF_W'(2 * N - 1);
    localparam logic [CSW:0]      CS_LIMIT  = (CSW + 1)'(NUM_CS);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [N-1:0]        sh_q, sh_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                rd_q, rd_d;
    logic                cpha_q, cpha_d;
    logic                cpol_q, cpol_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [N-1:0]        frame;
    logic                div_end;

    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        sh_d      = sh_q;
        shadow_d  = shadow_q;
        rd_data_d = rd_data_q;
        cs_n_d    = cs_n_q;
        rd_d      = rd_q;
        cpha_d    = cpha_q;
        cpol_d    = cpol_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        frame     = '0;

        case (state_q)
            IDLE: begin
                cpol_d = bus.cpol;
                sclk_d = bus.cpol;
                cs_n_d = '1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    if ({1'b0, bus.cs_sel} < CS_LIMIT) begin
                        state_d = SETUP;
                        div_d   = '0;
                        rd_d    = bus.rd_wr;
                        cpha_d  = bus.cpha;
                        busy_d  = 1'b1;
                        cs_n_d  = ~(NUM_CS'(1) << bus.cs_sel);
                        frame   = {bus.rd_wr, bus.address,
                                   bus.rd_wr ? {DATA_W{1'b0}} : bus.wr_data};
                        // cpha=0 presents the first bit before the first edge
                        if (bus.cpha) begin
                            sh_d = frame;
                        end else begin
                            mosi_d = frame[N-1];
                            sh_d   = frame << 1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SETUP: begin
                if (div_end) begin
                    state_d = XFER;
                    half_d  = HALF_W'(1);
                    div_d   = '0;
                    sclk_d  = ~sclk_q;
                    if (cpha_q) begin
                        mosi_d = sh_q[N-1];
                        sh_d   = sh_q << 1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            XFER: begin
                // odd half-periods are leading edges; cpha picks which edge samples
                if (div_q == '0 && (half_q[0] != cpha_q))
                    shadow_d = (shadow_q << 1) | DATA_W'(bus.miso);
                if (div_end) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = HOLD;
                        sclk_d  = cpol_q;
                        mosi_d  = 1'b0;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        sclk_d = ~sclk_q;
                        if (half_q[0] == 1'b0) begin
                            if (cpha_q) begin
                                mosi_d = sh_q[N-1];
                                sh_d   = sh_q << 1;
                            end
                        end else if (!cpha_q && half_q != HALF_PEN) begin
                            mosi_d = sh_q[N-1];
                            sh_d   = sh_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                mosi_d = 1'b0;
                if (div_end) begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rd_q)
                        rd_data_d = shadow_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            half_q    <= '0;
            sh_q      <= '0;
            shadow_q  <= '0;
            rd_data_q <= '0;
            cs_n_q    <= '1;
            rd_q      <= 1'b0;
            cpha_q    <= 1'b0;
            cpol_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            sh_q      <= sh_d;
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
            cs_n_q    <= cs_n_d;
            rd_q      <= rd_d;
            cpha_q    <= cpha_d;
            cpol_q    <= cpol_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.mosi    = mosi_q;
    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: three builds (CLK_DIV 2/1/5, NUM_CS 4/3/4)
// sharing one SPI slave model that is steered to whichever build is active.
module tb_spi_master_gen;
    logic mclk = 1'b0;
    logic reset = 1'b0;
    always #5 mclk = ~mclk;

    logic [2:0] start_v = '0;
    logic       rd_wr = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
    logic [1:0] cs_sel = '0;
    logic [6:0] address = '0;
    logic [7:0] wr_data = '0;

    spi_master_gen_if #(.ADDR_W(7), .DATA_W(8), .NUM_CS(4), .CSW(2)) bus0 ();
    spi_master_gen_if #(.ADDR_W(7), .DATA_W(8), .NUM_CS(3), .CSW(2)) bus1 ();
    spi_master_gen_if #(.ADDR_W(7), .DATA_W(8), .NUM_CS(4), .CSW(2)) bus2 ();

    spi_master_gen #(.ADDR_W(7), .DATA_W(8), .NUM_CS(4), .CLK_DIV(2), .CSW(2))
        u0 (.mclk(mclk), .reset(reset), .bus(bus0));
    spi_master_gen #(.ADDR_W(7), .DATA_W(8), .NUM_CS(3), .CLK_DIV(1), .CSW(2))
        u1 (.mclk(mclk), .reset(reset), .bus(bus1));
    spi_master_gen #(.ADDR_W(7), .DATA_W(8), .NUM_CS(4), .CLK_DIV(5), .CSW(2))
        u2 (.mclk(mclk), .reset(reset), .bus(bus2));

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.rd_wr = rd_wr;   assign bus1.rd_wr = rd_wr;   assign bus2.rd_wr = rd_wr;
    assign bus0.cs_sel = cs_sel; assign bus1.cs_sel = cs_sel; assign bus2.cs_sel = cs_sel;
    assign bus0.cpol = cpol;     assign bus1.cpol = cpol;     assign bus2.cpol = cpol;
    assign bus0.cpha = cpha;     assign bus1.cpha = cpha;     assign bus2.cpha = cpha;
    assign bus0.address = address; assign bus1.address = address; assign bus2.address = address;
    assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data; assign bus2.wr_data = wr_data;
    assign bus0.miso = miso;     assign bus1.miso = miso;     assign bus2.miso = miso;

    int unsigned sel = 0;
    logic       m_sclk, m_mosi, m_busy, m_done, m_err;
    logic [3:0] m_csn;
    logic [7:0] m_rdd;

    always_comb begin
        m_sclk = bus0.sclk; m_mosi = bus0.mosi; m_busy = bus0.busy;
        m_done = bus0.done; m_err = bus0.err; m_csn = bus0.cs_n; m_rdd = bus0.rd_data;
        case (sel)
            1: begin
                m_sclk = bus1.sclk; m_mosi = bus1.mosi; m_busy = bus1.busy;
                m_done = bus1.done; m_err = bus1.err; m_csn = {1'b1, bus1.cs_n}; m_rdd = bus1.rd_data;
            end
            2: begin
                m_sclk = bus2.sclk; m_mosi = bus2.mosi; m_busy = bus2.busy;
                m_done = bus2.done; m_err = bus2.err; m_csn = bus2.cs_n; m_rdd = bus2.rd_data;
            end
            default: ;
        endcase
    end

    // Slave model: captures mosi on sampling edges, launches miso on the other edge.
    int unsigned cyc = 0;
    logic        cur_cpol = 1'b0, cur_cpha = 1'b0, act_prev = 1'b0, sclk_prev = 1'b0;
    logic [15:0] tx_frame = '0, tx_sh = '0, rx = '0;
    int unsigned edges = 0, first_e = 0, last_e = 0, min_gap = 0, max_gap = 0, gap = 0, cs_viol = 0;

    always @(negedge mclk) begin
        if (m_busy === 1'b1 && $countones(~m_csn) != 1) cs_viol++;
        if (m_busy === 1'b0 && m_csn !== 4'hF) cs_viol++;
        if (m_csn !== 4'hF && reset) begin
            if (!act_prev) begin
                edges = 0; rx = '0; first_e = 0; last_e = 0; min_gap = 1000; max_gap = 0;
                tx_sh = tx_frame;
                if (!cur_cpha) begin miso = tx_sh[15]; tx_sh = tx_sh << 1; end
            end else if (m_sclk != sclk_prev) begin
                if (edges == 0) first_e = cyc;
                else begin
                    gap = cyc - last_e;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                last_e = cyc;
                edges++;
                if ((m_sclk != cur_cpol) != cur_cpha) rx = {rx[14:0], m_mosi};
                else begin miso = tx_sh[15]; tx_sh = tx_sh << 1; end
            end
        end
        act_prev  = (m_csn !== 4'hF) && reset;
        sclk_prev = m_sclk;
    end

    int unsigned total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int unsigned inst;
        logic        rd;
        logic [1:0]  cs;
        logic        cpol;
        logic        cpha;
        logic [6:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  stx;
        logic [3:0]  csn;
        logic [15:0] frame;
        logic [7:0]  rdd;
    } vec_t;

    vec_t tbl[8];
    int unsigned lat_of[3]   = '{69, 35, 171};
    int unsigned first_of[3] = '{3, 2, 6};
    int unsigned last_of[3]  = '{65, 33, 161};
    int unsigned gap_of[3]   = '{2, 1, 5};

    task automatic start_cmd(input vec_t v);
        sel = v.inst; cur_cpol = v.cpol; cur_cpha = v.cpha; tx_frame = {8'h00, v.stx};
        rd_wr = v.rd; cs_sel = v.cs; cpol = v.cpol; cpha = v.cpha;
        address = v.addr; wr_data = v.wd;
        start_v = '0; start_v[v.inst] = 1'b1; cyc = 0;
    endtask

    task automatic step();
        @(posedge mclk); #1;
        cyc++;
        start_v = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(posedge mclk); #1;
        start_cmd(v);
        step();
        chk($sformatf("v%0d_busy", idx), m_busy, 1);
        chk($sformatf("v%0d_csn", idx), m_csn, v.csn);
        while (!m_done && cyc < 400) step();
        chk($sformatf("v%0d_latency", idx), cyc, lat_of[v.inst]);
        chk($sformatf("v%0d_rd_data", idx), m_rdd, v.rdd);
        chk($sformatf("v%0d_frame", idx), rx, v.frame);
        chk($sformatf("v%0d_edges", idx), edges, 32);
        chk($sformatf("v%0d_first_edge", idx), first_e, first_of[v.inst]);
        chk($sformatf("v%0d_last_edge", idx), last_e, last_of[v.inst]);
        chk($sformatf("v%0d_gap_min", idx), min_gap, gap_of[v.inst]);
        chk($sformatf("v%0d_gap_max", idx), max_gap, gap_of[v.inst]);
        chk($sformatf("v%0d_idle_sclk", idx), m_sclk, v.cpol);
        chk($sformatf("v%0d_done_csn", idx), m_csn, 4'hF);
        chk($sformatf("v%0d_done_mosi", idx), m_mosi, 0);
    endtask

    initial begin
        vec_t v;
        int unsigned dn;
        //            inst rd  cs    cpol cpha addr   wd     stx    csn      frame     rdd
        tbl[0] = '{0, 1'b0, 2'd1, 1'b0, 1'b0, 7'h2A, 8'hC3, 8'h5A, 4'b1101, 16'h2AC3, 8'h00};
        tbl[1] = '{0, 1'b1, 2'd2, 1'b1, 1'b1, 7'h05, 8'h00, 8'hA5, 4'b1011, 16'h8500, 8'hA5};
        tbl[2] = '{0, 1'b0, 2'd0, 1'b0, 1'b1, 7'h7F, 8'h81, 8'h33, 4'b1110, 16'h7F81, 8'hA5};
        tbl[3] = '{1, 1'b1, 2'd2, 1'b1, 1'b0, 7'h00, 8'h00, 8'h3C, 4'b1011, 16'h8000, 8'h3C};
        tbl[4] = '{1, 1'b0, 2'd0, 1'b0, 1'b1, 7'h55, 8'h0F, 8'hFF, 4'b1110, 16'h550F, 8'h3C};
        tbl[5] = '{2, 1'b1, 2'd3, 1'b0, 1'b0, 7'h12, 8'h00, 8'h96, 4'b0111, 16'h9200, 8'h96};
        tbl[6] = '{2, 1'b0, 2'd1, 1'b1, 1'b1, 7'h40, 8'hFF, 8'h00, 4'b1101, 16'h40FF, 8'h96};
        tbl[7] = '{0, 1'b1, 2'd1, 1'b0, 1'b0, 7'h33, 8'h00, 8'h77, 4'b1101, 16'hB300, 8'h77};

        repeat (3) @(posedge mclk);
        #1;
        chk("rst_csn", m_csn, 4'hF);
        chk("rst_sclk", m_sclk, 0);
        chk("rst_mosi", m_mosi, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_err", m_err, 0);
        chk("rst_rd_data", m_rdd, 8'h00);
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

        // back-to-back: second request in the done cycle of the first
        run_vec(20, tbl[2]);
        v = '{0, 1'b0, 2'd3, 1'b0, 1'b0, 7'h11, 8'h22, 8'h00, 4'b0111, 16'h1122, 8'hA5};
        start_cmd(v);
        chk("b2b_gap_csn", m_csn, 4'hF);
        step();
        chk("b2b_csn", m_csn, 4'b0111);
        chk("b2b_busy", m_busy, 1);
        while (cyc < 20) step();
        start_v[0] = 1'b1; cs_sel = 2'd0;
        step();
        chk("midstart_err", m_err, 0);
        chk("midstart_csn", m_csn, 4'b0111);
        while (!m_done && cyc < 400) step();
        chk("b2b_latency", cyc, 69);
        chk("b2b_frame", rx, 16'h1122);

        // rejected select on the 3-select build
        @(posedge mclk); #1;
        v = '{1, 1'b0, 2'd3, 1'b0, 1'b0, 7'h01, 8'h01, 8'h00, 4'b1111, 16'h0000, 8'h3C};
        start_cmd(v);
        step();
        chk("err_pulse", m_err, 1);
        chk("err_busy", m_busy, 0);
        chk("err_csn", m_csn, 4'hF);
        step();
        chk("err_clear", m_err, 0);
        chk("err_busy2", m_busy, 0);

        // reset in the middle of a transfer
        @(posedge mclk); #1;
        v = '{0, 1'b1, 2'd2, 1'b1, 1'b0, 7'h01, 8'h00, 8'hEE, 4'b1011, 16'h8100, 8'h00};
        start_cmd(v);
        while (cyc < 20) step();
        reset = 1'b0;
        step();
        chk("midrst_csn", m_csn, 4'hF);
        chk("midrst_sclk", m_sclk, 0);
        chk("midrst_busy", m_busy, 0);
        chk("midrst_rd_data", m_rdd, 8'h00);
        reset = 1'b1;
        cpol = 1'b0;
        dn = 0;
        repeat (80) begin
            step();
            if (m_done) dn++;
        end
        chk("midrst_no_done", dn, 0);
        run_vec(7, tbl[7]);

        chk("cs_onehot", cs_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
